// File: rtl/wr_resp_tracker.sv
// ---------------------------------------------------------------------------
// wr_resp_tracker
//
// Per-channel AXI write-response tracker. Each channel counts accepted AW
// handshakes against completed B handshakes. It reports the outstanding count
// and idle/full status, throttles AWREADY while a channel is full, and raises
// a sticky underflow flag when a B arrives with nothing outstanding.
//
// Optional feature: define WR_RESP_TIMEOUT_EN to build a per-channel watchdog.
// The watchdog sets err_timeout when a channel waits too long for a response.
// Without the macro, err_timeout is tied to 0.
//
// Ports:
//   ACLK          clock, all state on the rising edge
//   ARESET        asynchronous active-high reset
//   aw_valid      per-channel AWVALID from the master
//   aw_ready_in   per-channel AWREADY from downstream
//   aw_ready_out  gated AWREADY to the master (aw_ready_in & ~full)
//   b_valid       per-channel BVALID
//   b_ready       per-channel BREADY
//   err_clear     pulse that clears every sticky error bit
//   outstanding   flat counts, channel i at [i*CNT_W +: CNT_W]
//   idle          count == 0, per channel
//   full          count == MAX_OUTSTANDING, per channel
//   all_idle      AND of idle
//   err_underflow sticky: B handshake seen with count 0
//   err_timeout   sticky watchdog flag
// ---------------------------------------------------------------------------
module wr_resp_tracker #(
    parameter int NUM_CH          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [NUM_CH-1:0]       aw_valid,
    input  logic [NUM_CH-1:0]       aw_ready_in,
    output logic [NUM_CH-1:0]       aw_ready_out,
    input  logic [NUM_CH-1:0]       b_valid,
    input  logic [NUM_CH-1:0]       b_ready,
    input  logic                    err_clear,
    output logic [NUM_CH*CNT_W-1:0] outstanding,
    output logic [NUM_CH-1:0]       idle,
    output logic [NUM_CH-1:0]       full,
    output logic                    all_idle,
    output logic [NUM_CH-1:0]       err_underflow,
    output logic [NUM_CH-1:0]       err_timeout
);

    // Reject parameter values that would make the counter or watchdog meaningless.
    if (MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("wr_resp_tracker: MAX_OUTSTANDING must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] err_uf_q, err_uf_d;
    logic [NUM_CH-1:0] issue, resp;

    // READY is the only combinational path through the block. A full channel
    // stays closed even in a cycle where a B completes. It reopens only once
    // the registered count has dropped.
    assign aw_ready_out = aw_ready_in & ~full;
    assign issue        = aw_valid & aw_ready_out;
    assign resp         = b_valid & b_ready;
    assign all_idle     = &idle;
    assign err_underflow = err_uf_q;

    // Status outputs decode only the registered count, so same-cycle
    // handshakes show up one cycle later.
    always_comb begin
        outstanding = '0;
        idle        = '0;
        full        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
            idle[i] = (cnt_q[i] == '0);
            full[i] = (cnt_q[i] == CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Count update. A stray B (count already 0) is dropped and flagged, but an
    // AW accepted in the same cycle still counts. err_clear loses against a
    // new error in the same cycle, so the sticky bit stays set.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            err_uf_d[i] = err_clear ? 1'b0 : err_uf_q[i];
            if (resp[i] && cnt_q[i] == '0) begin
                err_uf_d[i] = 1'b1;
                if (issue[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (issue[i] && !resp[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!issue[i] && resp[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Count and underflow state registers. Reset drops all outstanding
    // writes, so late B responses for them are later seen as underflow.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            err_uf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_uf_q <= err_uf_d;
        end
    end

`ifdef WR_RESP_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0]  tmr_q [NUM_CH];
    logic [TMR_W-1:0]  tmr_d [NUM_CH];
    logic [NUM_CH-1:0] err_to_q, err_to_d;

    assign err_timeout = err_to_q;

    // Watchdog timer. It advances while a channel has writes outstanding and
    // sees no response. It clears on any response or when the count is 0.
    // The timer saturates at TIMEOUT_CYCLES-1. The flag is raised in the same
    // cycle the timer reaches that value.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tmr_d[i]    = tmr_q[i];
            err_to_d[i] = err_clear ? 1'b0 : err_to_q[i];
            if (resp[i] || cnt_q[i] == '0) begin
                tmr_d[i] = '0;
            end else if (tmr_q[i] == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                err_to_d[i] = 1'b1;
            end else begin
                tmr_d[i] = tmr_q[i] + TMR_W'(1);
                if (tmr_q[i] == TMR_W'(TIMEOUT_CYCLES - 2)) begin
                    err_to_d[i] = 1'b1;
                end
            end
        end
    end

    // Watchdog state registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tmr_q[i] <= '0;
            end
            err_to_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tmr_q[i] <= tmr_d[i];
            end
            err_to_q <= err_to_d;
        end
    end
`else
    assign err_timeout = '0;
`endif

endmodule

// File: tb/tb_wr_resp_tracker.sv
// ---------------------------------------------------------------------------
// tb_wr_resp_tracker
//
// Self-checking bench for wr_resp_tracker with two channels and a depth of 4.
// The reference model keeps one integer count and one sticky underflow bit per
// channel. It applies the counting rules with plain arithmetic at every
// rising edge.
// ---------------------------------------------------------------------------
module tb_wr_resp_tracker;

    localparam int NCH   = 2;
    localparam int MAXO  = 4;
    localparam int CW    = 3;
    localparam int TOUT  = 8;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [1:0]      aw_valid, aw_ready_in, aw_ready_out;
    logic [1:0]      b_valid, b_ready;
    logic            err_clear;
    logic [NCH*CW-1:0] outstanding;
    logic [1:0]      idle, full, err_underflow, err_timeout;
    logic            all_idle;

    int errors = 0;
    int checks = 0;
    int mCnt [NCH];
    bit mUf  [NCH];

    wr_resp_tracker #(
        .NUM_CH         (NCH),
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .aw_valid     (aw_valid),
        .aw_ready_in  (aw_ready_in),
        .aw_ready_out (aw_ready_out),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .err_clear    (err_clear),
        .outstanding  (outstanding),
        .idle         (idle),
        .full         (full),
        .all_idle     (all_idle),
        .err_underflow(err_underflow),
        .err_timeout  (err_timeout)
    );

    // Free-running 10-time-unit clock.
    always #5 ACLK = ~ACLK;

    // Drive one cycle's worth of inputs. Callers are positioned just after a
    // rising edge.
    task automatic applyStimulus(input logic [1:0] awv, input logic [1:0] awr,
                                 input logic [1:0] bv, input logic [1:0] br,
                                 input logic clr);
        aw_valid    = awv;
        aw_ready_in = awr;
        b_valid     = bv;
        b_ready     = br;
        err_clear   = clr;
    endtask

    // Advance one rising edge and step the reference model with the inputs
    // that were present at that edge.
    task automatic tick();
        int iss, rsp;
        @(posedge ACLK);
        for (int ch = 0; ch < NCH; ch++) begin
            iss = (aw_valid[ch] && aw_ready_in[ch] && mCnt[ch] != MAXO) ? 1 : 0;
            rsp = (b_valid[ch] && b_ready[ch]) ? 1 : 0;
            if (err_clear) mUf[ch] = 1'b0;
            if (rsp == 1 && mCnt[ch] == 0) begin
                mUf[ch]  = 1'b1;
                mCnt[ch] = mCnt[ch] + iss;
            end else begin
                mCnt[ch] = mCnt[ch] + iss - rsp;
            end
        end
        #1;
    endtask

    // Return both channels to zero with B handshakes and clear the sticky bits.
    task automatic drainAll();
        for (int k = 0; k < 2 * MAXO && (mCnt[0] != 0 || mCnt[1] != 0); k++) begin
            applyStimulus(2'b00, 2'b11, {mCnt[1] != 0, mCnt[0] != 0}, 2'b11, 1'b0);
            tick();
        end
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 1'b1);
        tick();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
    endtask

    task automatic test_reset();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        ARESET = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin mCnt[ch] = 0; mUf[ch] = 1'b0; end
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) ARESET = 1'b0;
        tick();
        checks++; if (outstanding !== 6'd0) begin errors++; $display("[TB] FAIL reset_outstanding: got %h expected 0", outstanding); end
        checks++; if (idle !== 2'b11) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 11", idle); end
        checks++; if (all_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_all_idle: got %b expected 1", all_idle); end
        checks++; if (full !== 2'b00) begin errors++; $display("[TB] FAIL reset_full: got %b expected 00", full); end
        checks++; if (aw_ready_out !== 2'b11) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 11", aw_ready_out); end
        checks++; if (err_underflow !== 2'b00 || err_timeout !== 2'b00) begin errors++; $display("[TB] FAIL reset_errors: got uf=%b to=%b expected 00/00", err_underflow, err_timeout); end
    endtask

    task automatic test_fill_ch0();
        for (int k = 1; k <= MAXO; k++) begin
            applyStimulus(2'b01, 2'b11, 2'b00, 2'b11, 1'b0);
            tick();
            checks++; if (outstanding[2:0] !== 3'(k) || outstanding[5:3] !== 3'd0) begin errors++; $display("[TB] FAIL fill_count: got ch0=%0d ch1=%0d expected ch0=%0d ch1=0", outstanding[2:0], outstanding[5:3], k); end
        end
        checks++; if (full !== 2'b01 || idle !== 2'b10 || all_idle !== 1'b0) begin errors++; $display("[TB] FAIL fill_status: got full=%b idle=%b all=%b expected 01/10/0", full, idle, all_idle); end
        #1;
        checks++; if (aw_ready_out !== 2'b10) begin errors++; $display("[TB] FAIL fill_throttle: got ready=%b expected 10", aw_ready_out); end
        tick();
        checks++; if (outstanding[2:0] !== 3'd4) begin errors++; $display("[TB] FAIL fill_no_wrap: got %0d expected 4", outstanding[2:0]); end
    endtask

    task automatic test_full_release();
        applyStimulus(2'b01, 2'b11, 2'b01, 2'b01, 1'b0);
        #1;
        checks++; if (aw_ready_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL release_ready_low: got %b expected 0", aw_ready_out[0]); end
        tick();
        checks++; if (outstanding[2:0] !== 3'd3 || full[0] !== 1'b0) begin errors++; $display("[TB] FAIL release_dec: got cnt=%0d full=%b expected 3/0", outstanding[2:0], full[0]); end
        applyStimulus(2'b01, 2'b11, 2'b00, 2'b01, 1'b0);
        #1;
        checks++; if (aw_ready_out[0] !== 1'b1) begin errors++; $display("[TB] FAIL release_reopen: got %b expected 1", aw_ready_out[0]); end
        tick();
        checks++; if (outstanding[2:0] !== 3'd4) begin errors++; $display("[TB] FAIL release_refill: got %0d expected 4", outstanding[2:0]); end
        drainAll();
        checks++; if (outstanding !== 6'd0 || all_idle !== 1'b1) begin errors++; $display("[TB] FAIL drain: got %h all_idle=%b expected 0/1", outstanding, all_idle); end
    endtask

    task automatic test_simul_ch1();
        repeat (2) begin
            applyStimulus(2'b10, 2'b11, 2'b00, 2'b11, 1'b0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b10, 2'b11, 2'b10, 2'b11, 1'b0);
            tick();
            checks++; if (outstanding[5:3] !== 3'd2 || idle[1] !== 1'b0) begin errors++; $display("[TB] FAIL simul_hold: got cnt=%0d idle=%b expected 2/0", outstanding[5:3], idle[1]); end
        end
        drainAll();
    endtask

    task automatic test_underflow();
        applyStimulus(2'b00, 2'b11, 2'b10, 2'b10, 1'b0);
        tick();
        checks++; if (err_underflow !== 2'b10 || outstanding[5:3] !== 3'd0) begin errors++; $display("[TB] FAIL uf_set: got uf=%b cnt=%0d expected 10/0", err_underflow, outstanding[5:3]); end
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        tick();
        checks++; if (err_underflow !== 2'b00) begin errors++; $display("[TB] FAIL uf_clear: got %b expected 00", err_underflow); end
        applyStimulus(2'b00, 2'b11, 2'b10, 2'b10, 1'b1);
        tick();
        checks++; if (err_underflow !== 2'b10) begin errors++; $display("[TB] FAIL uf_clear_race: got %b expected 10", err_underflow); end
        applyStimulus(2'b10, 2'b11, 2'b10, 2'b10, 1'b1);
        tick();
        checks++; if (outstanding[5:3] !== 3'd1 || err_underflow !== 2'b10) begin errors++; $display("[TB] FAIL uf_with_issue: got cnt=%0d uf=%b expected 1/10", outstanding[5:3], err_underflow); end
        drainAll();
    endtask

    task automatic test_reset_mid();
        repeat (2) begin
            applyStimulus(2'b01, 2'b11, 2'b00, 2'b11, 1'b0);
            tick();
        end
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        ARESET = 1'b1;
        #1;
        checks++; if (outstanding !== 6'd0 || idle !== 2'b11) begin errors++; $display("[TB] FAIL async_reset: got %h idle=%b expected 0/11", outstanding, idle); end
        for (int ch = 0; ch < NCH; ch++) begin mCnt[ch] = 0; mUf[ch] = 1'b0; end
        @(negedge ACLK) ARESET = 1'b0;
        tick();
        applyStimulus(2'b00, 2'b11, 2'b01, 2'b01, 1'b0);
        tick();
        checks++; if (err_underflow !== 2'b01) begin errors++; $display("[TB] FAIL late_b_after_reset: got %b expected 01", err_underflow); end
        drainAll();
    endtask

    task automatic test_random();
        logic [1:0] expReady;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0));
            #1;
            for (int ch = 0; ch < NCH; ch++) expReady[ch] = aw_ready_in[ch] && (mCnt[ch] != MAXO);
            checks++; if (aw_ready_out !== expReady) begin errors++; $display("[TB] FAIL rand_ready: cycle %0d got %b expected %b", n, aw_ready_out, expReady); end
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                checks++;
                if (outstanding[ch*CW +: CW] !== 3'(mCnt[ch]) || idle[ch] !== (mCnt[ch] == 0) ||
                    full[ch] !== (mCnt[ch] == MAXO) || err_underflow[ch] !== mUf[ch]) begin
                    errors++;
                    $display("[TB] FAIL rand_state: cycle %0d ch%0d got cnt=%0d idle=%b full=%b uf=%b expected cnt=%0d uf=%b",
                             n, ch, outstanding[ch*CW +: CW], idle[ch], full[ch], err_underflow[ch], mCnt[ch], mUf[ch]);
                end
            end
            checks++; if (all_idle !== (mCnt[0] == 0 && mCnt[1] == 0)) begin errors++; $display("[TB] FAIL rand_all_idle: cycle %0d got %b", n, all_idle); end
        end
        drainAll();
    endtask

`ifdef WR_RESP_TIMEOUT_EN
    task automatic test_timeout();
        applyStimulus(2'b01, 2'b11, 2'b00, 2'b11, 1'b0);
        tick();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        repeat (TOUT - 2) tick();
        checks++; if (err_timeout !== 2'b00) begin errors++; $display("[TB] FAIL timeout_early: got %b expected 00", err_timeout); end
        tick();
        checks++; if (err_timeout !== 2'b01) begin errors++; $display("[TB] FAIL timeout_set: got %b expected 01", err_timeout); end
        repeat (3) tick();
        checks++; if (err_timeout !== 2'b01) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 01", err_timeout); end
        drainAll();
        applyStimulus(2'b01, 2'b11, 2'b00, 2'b11, 1'b0);
        tick();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        repeat (4) tick();
        applyStimulus(2'b00, 2'b11, 2'b01, 2'b11, 1'b0);
        tick();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        repeat (10) tick();
        checks++; if (err_timeout !== 2'b00) begin errors++; $display("[TB] FAIL timeout_avoided: got %b expected 00", err_timeout); end
    endtask
`else
    task automatic test_timeout();
        applyStimulus(2'b01, 2'b11, 2'b00, 2'b11, 1'b0);
        tick();
        applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        repeat (2 * TOUT) tick();
        checks++; if (err_timeout !== 2'b00) begin errors++; $display("[TB] FAIL timeout_tied: got %b expected 00", err_timeout); end
        drainAll();
    endtask
`endif

    initial begin
        ARESET = 1'b1;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        test_reset();
        test_fill_ch0();
        test_full_release();
        test_simul_ch1();
        test_underflow();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wr_resp_tracker.md
# wr_resp_tracker

Parametrised per-channel write-response tracker for the AXI interconnect. It counts accepted AW handshakes against completed B handshakes on each of NUM_CH channels and reports the outstanding count, idle status and full status per channel. When a channel reaches MAX_OUTSTANDING it throttles AWREADY, and it flags protocol underflow on a stray B. It sits between the master-side AW/B ports and the arbiter/decoder, and generalises the single-flag write-response handshake to counted, multi-channel tracking.

## Interface
- NUM_CH, 2, number of independent channels tracked
- MAX_OUTSTANDING, 4, maximum outstanding writes per channel (≥1)
- CNT_W, $clog2(MAX_OUTSTANDING+1), counter width (derived, not overridden)
- TIMEOUT_CYCLES, 256, watchdog limit (used only with WR_RESP_TIMEOUT_EN; ≥2)

- ACLK  in  1  clock, all state on rising edge
- ARESET  in  1  asynchronous, active-high reset
- aw_valid  in  NUM_CH  per-channel AWVALID
- aw_ready_in  in  NUM_CH  AWREADY from downstream
- aw_ready_out  out  NUM_CH  gated AWREADY to master = aw_ready_in & ~full (combinational)
- b_valid  in  NUM_CH  per-channel BVALID
- b_ready  in  NUM_CH  per-channel BREADY
- err_clear  in  1  single-cycle pulse, clears all sticky error bits
- outstanding  out  NUM_CH*CNT_W  flat counts, channel i at [i*CNT_W +: CNT_W]
- idle  out  NUM_CH  count==0
- full  out  NUM_CH  count==MAX_OUTSTANDING
- all_idle  out  1  AND of idle
- err_underflow  out  NUM_CH  sticky, B handshake seen with count 0
- err_timeout  out  NUM_CH  sticky watchdog flag (tied 0 without macro)

## Operation
- Issue on channel i: aw_valid[i] & aw_ready_out[i]. Response: b_valid[i] & b_ready[i].
- Per-channel count update, evaluated each cycle:
  - Issue only: +1.
  - Response only with count>0: −1.
  - Both with count>0: unchanged.
  - Response with count==0: B is ignored, err_underflow[i] is set, and count = count + issue.
- Count never exceeds MAX_OUTSTANDING. It cannot, because full forces aw_ready_out low. No wrap-around in either direction.
- idle, full and all_idle decode the registered count only. They are not bypassed by same-cycle events.
- Channels are fully independent. No cross-channel arbitration.
- err_clear clears every sticky bit. A new error event in the same cycle wins: the bit stays 1.

## Timing
- Reset (asynchronous assert, synchronous to ACLK on release):
  - count=0, idle=1, all_idle=1, full=0.
  - err_underflow=0, err_timeout=0, watchdog timers=0.
  - aw_ready_out follows aw_ready_in.
- Reset mid-transaction drops all outstanding counts to 0. Any later B for those writes is flagged as underflow.
- Latency: a handshake in cycle N is reflected in outstanding/idle/full in cycle N+1.
- Full throttling:
  - aw_ready_out[i] is 0 in every cycle where full[i]=1, including a cycle where a B completes.
  - READY reopens in the cycle after the decrement.
- aw_ready_out is the only combinational path: aw_ready_in → aw_ready_out. There is no path from valid to ready.

## Configuration
- WR_RESP_TIMEOUT_EN defined:
  - Per-channel timer of $clog2(TIMEOUT_CYCLES) bits. It increments while count>0 and there is no response that cycle.
  - The timer clears on any response or whenever count==0.
  - When the timer reaches TIMEOUT_CYCLES−1, err_timeout[i] is set (sticky) and the timer saturates.
- WR_RESP_TIMEOUT_EN undefined: no timer logic is compiled, err_timeout is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
- Reset with aw_ready_in=2'b11 → outstanding=0 for both channels, idle=2'b11, all_idle=1, aw_ready_out=2'b11, all errors 0.
- Ch0: 4 consecutive AW handshakes → outstanding0 = 1,2,3,4. full[0]=1 the cycle after the 4th, and aw_ready_out[0]=0 while aw_ready_in[0]=1. Ch1 is unaffected.
- Ch0 at 4, then simultaneous B handshake with aw_valid=1 → count goes to 3 and no AW is accepted that cycle. Next cycle, aw_ready_out[0]=1 and the AW is accepted, giving count 4.
- Ch1 at count 2, simultaneous AW and B for 3 cycles → count stays 2 and idle[1]=0.
- Ch1 idle, B handshake → err_underflow[1]=1 and count stays 0. err_clear pulse → flag returns to 0. err_clear coincident with a second stray B → flag stays 1.
- With WR_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=8: one AW on ch0 and no B → err_timeout[0]=1 after 7 cycles. Repeat with a B at cycle 5 → no flag.
